// File: rtl/module_ula_74181_seq_ctrl.sv
// Sequences one external 4-bit 74181 slice across NIBBLES nibbles, LSB first,
// rippling carry and accumulating the A=B flag into a W-bit result.
module module_ula_74181_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic [3:0]             op_s,
  input  logic                   op_m,
  input  logic                   op_cin,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [3:0]             alu_s,
  output logic                   alu_m,
  output logic                   alu_c_in,
  output logic                   alu_t,
  input  logic [3:0]             alu_f,
  input  logic                   alu_c_out,
  input  logic                   alu_a_eq_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry,
  output logic                   a_eq_b
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // state  | meaning
  // S_IDLE | waiting for start, outputs held
  // S_RUN  | one nibble per cycle through the slice
  // S_DONE | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_a, r_b, r_result;
  logic [3:0]      r_s;
  logic            r_m, r_cin, r_carry, r_eq;
  logic [IW-1:0]   r_idx;
  logic [IW+1:0]   w_ofs;
  logic            w_first, w_last;

  assign w_ofs   = {r_idx, 2'b00};
  assign w_first = (r_idx == '0);
  assign w_last  = (r_idx == IW'(NIBBLES - 1));

  assign result = r_result;
  assign carry  = r_carry;
  assign a_eq_b = r_eq;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    alu_a    = 4'd0;
    alu_b    = 4'd0;
    alu_s    = 4'd0;
    alu_m    = 1'b0;
    alu_c_in = 1'b0;
    alu_t    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        busy     = 1'b1;
        alu_a    = r_a[w_ofs +: 4];
        alu_b    = r_b[w_ofs +: 4];
        alu_s    = r_s;
        alu_m    = r_m;
        alu_t    = !w_first;
        alu_c_in = w_first ? r_cin : r_carry;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_m      <= 1'b0;
      r_cin    <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_eq     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= op_a;
            r_b   <= op_b;
            r_s   <= op_s;
            r_m   <= op_m;
            r_cin <= op_cin;
            r_idx <= '0;
            r_eq  <= 1'b1;
          end
        end
        S_RUN: begin
          r_result[w_ofs +: 4] <= alu_f;
          r_carry              <= alu_c_out;
          r_eq                 <= r_eq & alu_a_eq_b;
          r_idx                <= w_last ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_module_ula_74181_seq_ctrl.sv
// Randomized and directed checks of the nibble sequencer driving a
// behavioural 74181 slice, compared against a whole-word reference.
module tb_module_ula_74181_seq_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  op_a, op_b;
  logic [3:0]    op_s;
  logic          op_m, op_cin;
  logic [3:0]    alu_a, alu_b, alu_s, alu_f;
  logic          alu_m, alu_c_in, alu_t, alu_c_out, alu_a_eq_b;
  logic          busy, done, carry, a_eq_b;
  logic [W-1:0]  result;

  int n_vec = 0;
  int n_err = 0;
  logic t_seq [N];
  logic ci_seq[N];

  module_ula_74181_seq_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
    .alu_c_in(alu_c_in), .alu_t(alu_t),
    .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b),
    .busy(busy), .done(done), .result(result), .carry(carry), .a_eq_b(a_eq_b)
  );

  always #5 clk = ~clk;

  // 74181 logic-mode functions, active-high data
  function automatic logic [W-1:0] logic_fn(input logic [W-1:0] a, b, input logic [3:0] s);
    case (s)
      4'd0:  return ~a;
      4'd1:  return ~(a | b);
      4'd2:  return ~a & b;
      4'd3:  return '0;
      4'd4:  return ~(a & b);
      4'd5:  return ~b;
      4'd6:  return a ^ b;
      4'd7:  return a & ~b;
      4'd8:  return ~a | b;
      4'd9:  return ~(a ^ b);
      4'd10: return b;
      4'd11: return a & b;
      4'd12: return '1;
      4'd13: return a | ~b;
      4'd14: return a | b;
      default: return a;
    endcase
  endfunction

  // slice stand-in: arithmetic supports S=1001 (A plus B) and S=0000 (A)
  always_comb begin
    logic [W-1:0] lf;
    logic [4:0]   sum;
    lf  = logic_fn(W'(alu_a), W'(alu_b), alu_s);
    sum = 5'd0;
    if (alu_m) begin
      alu_f     = lf[3:0];
      alu_c_out = 1'b0;
    end else begin
      if (alu_s == 4'd9) sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_c_in};
      else               sum = {1'b0, alu_a} + {4'd0, alu_c_in};
      alu_f     = sum[3:0];
      alu_c_out = sum[4];
    end
    alu_a_eq_b = (alu_a == alu_b);
  end

  // whole-word reference: {eq, carry, result}
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, b, input logic [3:0] s,
                                          input logic m, cin);
    logic [W:0] sum;
    if (m) return {a == b, 1'b0, logic_fn(a, b, s)};
    if (s == 4'd9) sum = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    else           sum = {1'b0, a} + (W+1)'(cin);
    return {a == b, sum};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, b, input logic [3:0] s,
                        input logic m, cin, noise);
    int cyc;
    bit got;
    logic [W+1:0] e;
    op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin;
    start = 1'b1;
    tick;
    if (noise) begin
      op_a = '1; op_b = '0; op_s = 4'd0; op_cin = 1'b1;
    end else begin
      start = 1'b0;
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        if (cyc < N) begin
          chk("busy_run", busy, 1);
          chk("alu_a_nib", alu_a, (a >> (4 * cyc)) & 16'hF);
          chk("alu_b_nib", alu_b, (b >> (4 * cyc)) & 16'hF);
          t_seq[cyc]  = alu_t;
          ci_seq[cyc] = alu_c_in;
        end
        tick;
        cyc++;
      end
    end
    chk("done_seen", got, 1);
    chk("latency", cyc, N);
    e = ref_op(a, b, s, m, cin);
    chk("result", result, e[W-1:0]);
    chk("carry", carry, e[W]);
    chk("a_eq_b", a_eq_b, e[W+1]);
    chk("busy_done", busy, 0);
    chk("alu_zero_done", {alu_a, alu_b, alu_s, alu_m, alu_c_in, alu_t}, 0);
    chk("cin_idx0", ci_seq[0], cin);
    tick;
    start = 1'b0;
    @(negedge clk);
    chk("done_once", done, 0);
    chk("busy_idle", busy, 0);
    chk("alu_zero_idle", {alu_a, alu_b, alu_s, alu_m, alu_c_in, alu_t}, 0);
  endtask

  initial begin
    int dcnt;
    logic [3:0] rs;
    logic rm;
    rst = 1'b1; start = 1'b0;
    op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cin = 1'b0;
    tick; tick;
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_flags", {busy, done, carry, a_eq_b}, 0);
    chk("rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_c_in, alu_t}, 0);
    tick;
    rst = 1'b0;

    run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 1'b0);
    chk("add_result", result, 16'h2233);

    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
    chk("ripple_result", {carry, result}, 17'h10000);
    for (int i = 1; i < N; i++) chk("ripple_cin", ci_seq[i], 1);

    run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, 1'b0);
    chk("xor_result", {carry, result}, 17'h00FF0);
    for (int i = 0; i < N; i++) chk("alu_t_seq", t_seq[i], (i == 0) ? 0 : 1);

    run_op(16'hABCD, 16'hABCD, 4'b1111, 1'b1, 1'b0, 1'b0);
    chk("eq_pass", {a_eq_b, result}, 17'h1ABCD);
    run_op(16'hABCD, 16'hABCC, 4'b1111, 1'b1, 1'b0, 1'b0);
    chk("eq_fail", a_eq_b, 0);

    // busy rejection: start held high with junk operands through RUN and DONE
    run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 1'b1);
    chk("rej_result", result, 16'h2233);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || done) dcnt++;
      tick;
    end
    chk("rej_no_rerun", dcnt, 0);

    // reset on the second RUN cycle
    op_a = 16'h1111; op_b = 16'h2222; op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_carry", carry, 0);
    chk("abort_done", done, 0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcnt++;
      tick;
    end
    chk("abort_no_done", dcnt, 0);
    run_op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
    chk("post_abort_add", result, 16'h0002);

    for (int k = 0; k < 40; k++) begin
      rm = 1'($urandom_range(0, 1));
      if (rm) rs = 4'($urandom_range(0, 15));
      else    rs = ($urandom_range(0, 1) != 0) ? 4'd9 : 4'd0;
      run_op(16'($urandom), ($urandom_range(0, 3) == 0) ? 16'h5A5A : 16'($urandom),
             rs, rm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/module_ula_74181_seq_ctrl.md
MODULE_ULA_74181_SEQ_CTRL -- requirements
Module: module_ula_74181_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width as 4*NIBBLES bits (W).
REQ-002 The block SHALL have clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have start  input  1  request to run one operation; sampled only in IDLE.
REQ-005 The block SHALL have op_a, op_b  input  W each  wide operands.
REQ-006 The block SHALL have op_s  input  4  function select; op_m  input  1  mode (1 = logic, 0 = arithmetic); op_cin  input  1  carry-in.
REQ-007 The block SHALL have alu_a, alu_b, alu_s  output  4 each, alu_m, alu_c_in, alu_t  output  1 each: drive one 4-bit 74181 slice.
REQ-008 The block SHALL have alu_f  input  4, alu_c_out  input  1, alu_a_eq_b  input  1: slice response, combinational in the same cycle.
REQ-009 The block SHALL have busy  output  1, done  output  1, result  output  W, carry  output  1, a_eq_b  output  1.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-011 In IDLE with start=1, the block SHALL latch op_a, op_b, op_s, op_m and op_cin, clear nibble index idx to 0, set the eq accumulator to 1, and go to RUN.
REQ-012 In IDLE with start=0, the block SHALL stay in IDLE and hold result, carry and a_eq_b.
REQ-013 In RUN, alu_a and alu_b SHALL be nibble idx of the latched operands (bits 4*idx+3..4*idx), alu_s and alu_m SHALL be the latched values, and alu_t SHALL be 0 when idx=0 and 1 otherwise.
REQ-014 In RUN, alu_c_in SHALL be the latched op_cin when idx=0 and the carry register otherwise.
REQ-015 On each RUN edge, the block SHALL write alu_f into result nibble idx, write alu_c_out into the carry register, AND alu_a_eq_b into the eq accumulator, and increment idx.
REQ-016 When idx=NIBBLES-1 at a RUN edge, the block SHALL go to DONE after that nibble's capture.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-018 carry SHALL equal the carry register, and a_eq_b SHALL equal the eq accumulator; both are valid from DONE until the next accepted start.
REQ-019 busy SHALL be 1 in RUN only.
REQ-020 Latency SHALL be as follows: with start accepted at edge k, done is high in the cycle after edge k+NIBBLES, i.e. NIBBLES+1 cycles after start.
REQ-021 A start in RUN or DONE SHALL be ignored, with no queueing and no operand update.
REQ-022 Operand input changes during RUN SHALL have no effect, because only latched copies are used.
REQ-023 In IDLE and DONE, all alu_* outputs SHALL be driven to 0.
REQ-024 Carry SHALL be chained in both modes; in logic mode the slice returns c_out=0, so carry ends at 0.
REQ-025 result nibbles not yet written in the current run SHALL keep their previous values until overwritten; only the DONE-cycle value is defined.

Reset
REQ-026 With rst=1 at an edge, the block SHALL go to IDLE, with busy=0, done=0, result=0, carry=0, a_eq_b=0, idx=0, and all latched operands 0.
REQ-027 rst SHALL take priority over start and over any RUN capture in the same cycle.
REQ-028 A reset during RUN SHALL abort the operation with no done pulse; the next start after rst deasserts SHALL run normally.

Verification (NIBBLES=4, slice = the team's 74181 model)
REQ-029 Add: op_s=1001, op_m=0, op_a=0x1234, op_b=0x0FFF, op_cin=0, start pulse -> done exactly 5 cycles later, result=0x2233, carry=0.
REQ-030 Carry ripple: op_s=1001, op_m=0, op_a=0xFFFF, op_b=0x0001, op_cin=0 -> result=0x0000, carry=1; check alu_c_in=1 for idx 1..3.
REQ-031 Logic XOR: op_s=0110, op_m=1, op_a=0xF0F0, op_b=0xFF00 -> result=0x0FF0, carry=0; check alu_t sequence 0,1,1,1.
REQ-032 Equality: op_s=1111, op_m=1, op_a=op_b=0xABCD -> result=0xABCD, a_eq_b=1; rerun with op_b=0xABCC -> a_eq_b=0.
REQ-033 Reset mid-op: start, then rst=1 on the 2nd RUN cycle -> next cycle busy=0, result=0, carry=0, no done pulse; a fresh add of 0x0001+0x0001 -> result=0x0002.
REQ-034 Busy rejection: start with 0x1234+0x0FFF, then start=1 with op_a=0xFFFF during RUN and during DONE -> single done pulse, result=0x2233, busy never re-asserts without a new start in IDLE.
